xyolo_vec: RTL
==============

Name: xyolo_vec

Overview:
- N-lane, parametrised successor of the single-lane YOLO conv/activation/maxpool unit.
- Lane operations: accumulate pixel×weight over a programmable kernel length, add an optional pre-shifted bias, rescale with saturation, apply optional leaky-ReLU, and max-pool over a programmable number of consecutive results.
- Accumulation and pooling are sequenced by internal counters; the datapath is fed by valid/ready streams from the Versat data engine.

Parameters:
- DATAPATH_W, 16, lane data width (signed).
- N_LANES, 4, parallel lanes.
- ACC_W, 2*DATAPATH_W+8, accumulator width (signed).
- SHIFT_W, 5, width of the rescale shift.
- KER_W, 12, width of the kernel-length and output-count fields.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; latches cfg_* and begins a run when idle
- cfg_ker_len  in  KER_W  MAC beats per result; 0 treated as 1
- cfg_mp_len  in  2  results pooled per output = cfg_mp_len+1 (1..4)
- cfg_n_out  in  KER_W  output beats per run
- cfg_shift  in  SHIFT_W  rescale shift
- cfg_bias_en  in  1  initialise accumulator with bias<<shift
- cfg_leaky  in  1  enable leaky-ReLU (negative >>>3)
- cfg_bypass  in  1  result = pixel of the single beat (no MAC, no bias)
- in_valid  in  1  input beat valid
- in_ready  out  1  unit accepts a beat
- in_pixel  in  N_LANES*DATAPATH_W  packed lane pixels, lane 0 in LSBs
- in_weight  in  N_LANES*DATAPATH_W  packed lane weights
- in_bias  in  N_LANES*DATAPATH_W  packed lane biases; sampled on the first beat of each result
- out_valid  out  1  pooled output valid
- out_ready  in  1  consumer accepts the output
- out_data  out  N_LANES*DATAPATH_W  pooled outputs
- busy  out  1  a run is in progress
- done  out  1  one-cycle pulse when a run completes

Behaviour:
- **Reset values:** every output is 0, and every internal register and counter is 0. rst_n low at any point aborts a run; no done pulse is produced.
- **Configuration:** cfg_* are sampled only on start while in IDLE. start while busy is ignored. If the latched n_out is 0, go IDLE and pulse done on the next cycle.
- **FSM states:** IDLE, ACC, ACT, OUT.
  - IDLE: on start go to ACC. Clear ker_cnt, mp_cnt and out_cnt; busy=1.
  - ACC: in_ready=1. A beat transfers when in_valid&in_ready.
    - First beat of a result: acc = init + product, where init = sext(bias)<<<shift if bias_en, else 0.
    - Later beats: acc += product, where product = signed pixel×signed weight, sign-extended to ACC_W. The accumulator wraps on overflow.
    - After ker_len transfers go to ACT. In bypass mode, go after 1 transfer with acc = sext(pixel).
  - ACT (1 cycle, in_ready=0):
    - s = acc>>>shift (arithmetic), saturated to the signed DATAPATH_W range. In bypass, no shift or saturation; the value is passed through.
    - If leaky and s<0, then r = s>>>3; otherwise r = s.
    - If mp_cnt==0, load pool = r; otherwise pool = signed max(pool, r).
    - If mp_cnt==mp_len, load out_data=pool, assert out_valid and go to OUT. Otherwise mp_cnt++ and return to ACC.
  - OUT: in_ready=0, and out_valid and out_data stay stable until out_ready.
    - On handshake: out_valid=0 and out_cnt++.
    - If out_cnt reaches n_out: done=1 for one cycle, busy=0, go IDLE.
    - Otherwise clear mp_cnt and return to ACC.
    - If out_ready was already high, the handshake completes in the cycle out_valid rises.
- **Timing:**
  - Minimum latency from the last beat of a pooled group to out_valid is 2 cycles (ACT, then register).
  - Throughput is (ker_len+1)×(mp_len+1)+1 cycles per output at full handshake rate.
- **Lanes:** all lanes share the control path; lane datapaths are fully independent.
- in_valid low in ACC stalls with no state change.

Decomposition:
- Package xyolo_vec_pkg:
  - FSM state enumeration.
  - Saturation limits as functions of width.
  - Lane slice helper macros.
- Sub-module xyolo_vec_lane (instantiated N_LANES times) contains:
  - Lane datapath: MAC accumulator, shift/saturate, leaky, pool register.
  - Controls driven from the top: first_beat, acc_en, act_en, pool_first.
- The top holds the FSM, counters, handshakes and configuration registers.

Test Plan:
1. **Basic MAC:** N_LANES=4, ker_len=3, mp_len=0, n_out=1, shift=0, pixels {1,2,3}, weights {2,2,2} on all lanes → one output of 12 per lane; done one cycle after the handshake.
2. **Bias and leaky:** bias_en=1, bias=-4, shift=2, leaky=1, pixels×weights summing to -16 → acc=-32, s=-8, r=-1.
3. **Saturation:** DATAPATH_W=16, pixel=weight=32767, ker_len=4, shift=0 → 32767. Negative case (pixel=-32768, weight=32767) → -32768.
4. **Maxpool:** mp_len=3, ker_len=1, bypass=1, pixels per lane {5,-3,9,7} → output 9. Lane 1 fed {-8,-2,-6,-5} → -2.
5. **Backpressure:** out_ready held 0 for 10 cycles → out_valid/out_data stable and in_ready=0 throughout. Release, then run n_out=3 → exactly 3 beats, then a single done pulse.
6. **Reset and edge configuration:**
   - rst_n asserted mid-ACC (ker_len=100 after 50 beats) → all outputs 0 immediately, no done.
   - After release, start with n_out=0 → done on the next cycle, no out_valid.
   - ker_len=0 behaves as 1.

Source files
------------

// File: rtl/xyolo_vec_pkg.sv
// -----------------------------------------------------------------------------
// xyolo_vec_pkg
// Shared definitions for the N-lane YOLO conv/activation/maxpool unit:
//   - state_e   : control FSM states
//   - sat_max / sat_min : signed saturation limits for a given width, returned
//                 in a wide signed container so callers can compare any
//                 accumulator width against them
//   - XYOLO_SLICE macro : picks lane <idx> out of a packed lane bus
// -----------------------------------------------------------------------------
package xyolo_vec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_ACT  = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    // Container width for saturation comparisons; must exceed ACC_W.
    localparam int SAT_W = 64;

    // Largest signed value representable in w bits.
    function automatic logic signed [SAT_W-1:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    endfunction

    // Smallest signed value representable in w bits.
    function automatic logic signed [SAT_W-1:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 32'd1));
    endfunction

endpackage

`ifndef XYOLO_SLICE
`define XYOLO_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

// File: rtl/xyolo_vec_lane.sv
// -----------------------------------------------------------------------------
// xyolo_vec_lane
// One lane datapath: MAC accumulator, arithmetic rescale with saturation,
// optional leaky-ReLU and running max-pool register plus output register.
// Ports:
//   clk, rst_n            clock / async active-low reset
//   first_beat_i          current beat is the first of a result (load init)
//   acc_en_i              a beat transfers this cycle
//   act_en_i              activation cycle: update pool register
//   pool_first_i          first result of a pooled group (load, not max)
//   out_load_i            capture the pooled value into the output register
//   bypass_i/bias_en_i/leaky_i/shift_i   latched run configuration
//   pixel_i/weight_i/bias_i              lane operands
//   out_o                 registered pooled output
// -----------------------------------------------------------------------------
module xyolo_vec_lane
    import xyolo_vec_pkg::*;
#(
    parameter int DATAPATH_W = 16,
    parameter int ACC_W      = 2*DATAPATH_W+8,
    parameter int SHIFT_W    = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         first_beat_i,
    input  logic                         acc_en_i,
    input  logic                         act_en_i,
    input  logic                         pool_first_i,
    input  logic                         out_load_i,
    input  logic                         bypass_i,
    input  logic                         bias_en_i,
    input  logic                         leaky_i,
    input  logic [SHIFT_W-1:0]           shift_i,
    input  logic [DATAPATH_W-1:0]        pixel_i,
    input  logic [DATAPATH_W-1:0]        weight_i,
    input  logic [DATAPATH_W-1:0]        bias_i,
    output logic signed [DATAPATH_W-1:0] out_o
);

    localparam int DW  = DATAPATH_W;
    localparam int PW  = 2*DATAPATH_W;

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DW-1:0]     pool_q, pool_d;
    logic signed [DW-1:0]     out_q, out_d;

    logic signed [PW-1:0]     pix_w_s, wgt_w_s, prod_s;
    logic signed [ACC_W-1:0]  prod_ext_s, pix_ext_s, bias_ext_s, init_s;
    logic signed [ACC_W-1:0]  sh_s;
    logic signed [SAT_W-1:0]  sh_wide_s;
    logic signed [DW-1:0]     s_s, r_s, pool_next_s;

    // MAC path: operands widened before multiply so the full product is kept.
    always_comb begin
        pix_w_s    = {{DW{pixel_i[DW-1]}}, pixel_i};
        wgt_w_s    = {{DW{weight_i[DW-1]}}, weight_i};
        prod_s     = pix_w_s * wgt_w_s;
        prod_ext_s = {{(ACC_W-PW){prod_s[PW-1]}}, prod_s};
        pix_ext_s  = {{(ACC_W-DW){pixel_i[DW-1]}}, pixel_i};
        bias_ext_s = {{(ACC_W-DW){bias_i[DW-1]}}, bias_i};
        if (bias_en_i) begin
            init_s = bias_ext_s <<< shift_i;
        end else begin
            init_s = '0;
        end
        if (!acc_en_i) begin
            acc_d = acc_q;
        end else if (bypass_i) begin
            acc_d = pix_ext_s;
        end else if (first_beat_i) begin
            acc_d = init_s + prod_ext_s;
        end else begin
            acc_d = acc_q + prod_ext_s;
        end
    end

    // Activation path: rescale + saturate (skipped in bypass), leaky, max-pool.
    always_comb begin
        sh_s      = acc_q >>> shift_i;
        sh_wide_s = {{(SAT_W-ACC_W){sh_s[ACC_W-1]}}, sh_s};
        if (bypass_i) begin
            s_s = acc_q[DW-1:0];
        end else if (sh_wide_s > sat_max(DW)) begin
            s_s = {1'b0, {(DW-1){1'b1}}};
        end else if (sh_wide_s < sat_min(DW)) begin
            s_s = {1'b1, {(DW-1){1'b0}}};
        end else begin
            s_s = sh_wide_s[DW-1:0];
        end
        if (leaky_i && s_s[DW-1]) begin
            r_s = s_s >>> 3'd3;
        end else begin
            r_s = s_s;
        end
        if (pool_first_i) begin
            pool_next_s = r_s;
        end else if (r_s > pool_q) begin
            pool_next_s = r_s;
        end else begin
            pool_next_s = pool_q;
        end
        if (act_en_i) begin
            pool_d = pool_next_s;
        end else begin
            pool_d = pool_q;
        end
        // The output register sees the pool value including this cycle's result.
        if (act_en_i && out_load_i) begin
            out_d = pool_next_s;
        end else begin
            out_d = out_q;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            pool_q <= '0;
            out_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            pool_q <= pool_d;
            out_q  <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/xyolo_vec.sv
// -----------------------------------------------------------------------------
// xyolo_vec
// N-lane conv/activation/maxpool unit. The top holds the run FSM, the kernel,
// pool and output counters, the stream handshakes and the configuration
// registers; N_LANES identical lane datapaths share its control strobes.
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   start, cfg_*               run start pulse and run configuration
//   in_valid/in_ready          input beat stream (in_pixel/in_weight/in_bias)
//   out_valid/out_ready        pooled output stream (out_data)
//   busy, done                 run in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module xyolo_vec
    import xyolo_vec_pkg::*;
#(
    parameter int DATAPATH_W = 16,
    parameter int N_LANES    = 4,
    parameter int ACC_W      = 2*DATAPATH_W+8,
    parameter int SHIFT_W    = 5,
    parameter int KER_W      = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [KER_W-1:0]              cfg_ker_len,
    input  logic [1:0]                    cfg_mp_len,
    input  logic [KER_W-1:0]              cfg_n_out,
    input  logic [SHIFT_W-1:0]            cfg_shift,
    input  logic                          cfg_bias_en,
    input  logic                          cfg_leaky,
    input  logic                          cfg_bypass,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_LANES*DATAPATH_W-1:0] in_pixel,
    input  logic [N_LANES*DATAPATH_W-1:0] in_weight,
    input  logic [N_LANES*DATAPATH_W-1:0] in_bias,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_LANES*DATAPATH_W-1:0] out_data,
    output logic                          busy,
    output logic                          done
);

    localparam logic [KER_W-1:0] KER_ONE = {{(KER_W-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [KER_W-1:0]     ker_cnt_q, ker_cnt_d;
    logic [1:0]           mp_cnt_q, mp_cnt_d;
    logic [KER_W-1:0]     out_cnt_q, out_cnt_d;
    logic [KER_W-1:0]     ker_len_q, ker_len_d;
    logic [1:0]           mp_len_q, mp_len_d;
    logic [KER_W-1:0]     n_out_q, n_out_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic                 bias_en_q, bias_en_d;
    logic                 leaky_q, leaky_d;
    logic                 bypass_q, bypass_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [KER_W-1:0]     eff_ker_s;
    logic                 beat_s, last_beat_s;
    logic                 first_beat_s, acc_en_s, act_en_s, pool_first_s, out_load_s;

    // Kernel length 0 is run as 1; bypass always ends a result after one beat.
    always_comb begin
        if (ker_len_q == '0) begin
            eff_ker_s = KER_ONE;
        end else begin
            eff_ker_s = ker_len_q;
        end
        beat_s      = in_valid && in_ready_q;
        last_beat_s = bypass_q || (ker_cnt_q == (eff_ker_s - KER_ONE));
    end

    // Next-state, counter and control-strobe logic.
    always_comb begin
        state_d      = state_q;
        ker_cnt_d    = ker_cnt_q;
        mp_cnt_d     = mp_cnt_q;
        out_cnt_d    = out_cnt_q;
        ker_len_d    = ker_len_q;
        mp_len_d     = mp_len_q;
        n_out_d      = n_out_q;
        shift_d      = shift_q;
        bias_en_d    = bias_en_q;
        leaky_d      = leaky_q;
        bypass_d     = bypass_q;
        out_valid_d  = out_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        first_beat_s = 1'b0;
        acc_en_s     = 1'b0;
        act_en_s     = 1'b0;
        pool_first_s = 1'b0;
        out_load_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ker_len_d = cfg_ker_len;
                    mp_len_d  = cfg_mp_len;
                    n_out_d   = cfg_n_out;
                    shift_d   = cfg_shift;
                    bias_en_d = cfg_bias_en;
                    leaky_d   = cfg_leaky;
                    bypass_d  = cfg_bypass;
                    ker_cnt_d = '0;
                    mp_cnt_d  = 2'd0;
                    out_cnt_d = '0;
                    // An empty run completes without ever leaving IDLE.
                    if (cfg_n_out == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_ACC;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                first_beat_s = (ker_cnt_q == '0);
                if (beat_s) begin
                    acc_en_s = 1'b1;
                    if (last_beat_s) begin
                        ker_cnt_d = '0;
                        state_d   = ST_ACT;
                    end else begin
                        ker_cnt_d = ker_cnt_q + KER_ONE;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_ACT: begin
                act_en_s     = 1'b1;
                pool_first_s = (mp_cnt_q == 2'd0);
                if (mp_cnt_q == mp_len_q) begin
                    out_load_s  = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else begin
                    mp_cnt_d = mp_cnt_q + 2'd1;
                    state_d  = ST_ACC;
                end
            end
            ST_OUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_cnt_d   = out_cnt_q + KER_ONE;
                    if ((out_cnt_q + KER_ONE) == n_out_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        mp_cnt_d = 2'd0;
                        state_d  = ST_ACC;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
        in_ready_d = (state_d == ST_ACC);
    end

    // Control-path registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ker_cnt_q   <= '0;
            mp_cnt_q    <= 2'd0;
            out_cnt_q   <= '0;
            ker_len_q   <= '0;
            mp_len_q    <= 2'd0;
            n_out_q     <= '0;
            shift_q     <= '0;
            bias_en_q   <= 1'b0;
            leaky_q     <= 1'b0;
            bypass_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ker_cnt_q   <= ker_cnt_d;
            mp_cnt_q    <= mp_cnt_d;
            out_cnt_q   <= out_cnt_d;
            ker_len_q   <= ker_len_d;
            mp_len_q    <= mp_len_d;
            n_out_q     <= n_out_d;
            shift_q     <= shift_d;
            bias_en_q   <= bias_en_d;
            leaky_q     <= leaky_d;
            bypass_q    <= bypass_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        logic signed [DATAPATH_W-1:0] lane_out_s;

        xyolo_vec_lane #(
            .DATAPATH_W (DATAPATH_W),
            .ACC_W      (ACC_W),
            .SHIFT_W    (SHIFT_W)
        ) u_lane (
            .clk          (clk),
            .rst_n        (rst_n),
            .first_beat_i (first_beat_s),
            .acc_en_i     (acc_en_s),
            .act_en_i     (act_en_s),
            .pool_first_i (pool_first_s),
            .out_load_i   (out_load_s),
            .bypass_i     (bypass_q),
            .bias_en_i    (bias_en_q),
            .leaky_i      (leaky_q),
            .shift_i      (shift_q),
            .pixel_i      (`XYOLO_SLICE(in_pixel, g, DATAPATH_W)),
            .weight_i     (`XYOLO_SLICE(in_weight, g, DATAPATH_W)),
            .bias_i       (`XYOLO_SLICE(in_bias, g, DATAPATH_W)),
            .out_o        (lane_out_s)
        );

        assign `XYOLO_SLICE(out_data, g, DATAPATH_W) = lane_out_s;
    end

endmodule
